// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// The optional FETCH_STATS_EN counters live in fetch_unit.
package fetch_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    localparam int unsigned DEF_DATA_SIZE = 32;
    localparam int unsigned DEF_ADDR_SIZE = 10;

    // Default-sized entry; modules re-declare it from their own parameters.
    typedef struct packed {
        logic [DEF_ADDR_SIZE+1:0] pc;
        logic [DEF_DATA_SIZE-1:0] inst;
    } fetch_entry_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of packed fetch entries.
// A flush clears the queue and takes priority over a same-cycle push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned WIDTH = 44,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count,
    output logic [WIDTH-1:0] head
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, reads a 1-cycle ROM, queues
// {pc, inst} for IF/ID. Optional statistics counters under FETCH_STATS_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 redirect,
    input  logic [ADDR_SIZE+1:0] redirect_pc,
    output logic [ADDR_SIZE-1:0] iaddr,
    output logic                 ireq,
    input  logic [DATA_SIZE-1:0] idata,
    input  logic                 id_ready,
    output logic                 inst_valid,
    output logic [DATA_SIZE-1:0] inst_if,
    output logic [ADDR_SIZE+1:0] pc_if,
    output logic [31:0]          fetch_count,
    output logic [31:0]          flush_count
);

    localparam int unsigned PC_W    = ADDR_SIZE + 2;
    localparam int unsigned PTR_W   = ptr_width(DEPTH);
    localparam int unsigned ENTRY_W = PC_W + DATA_SIZE;
    localparam logic [PTR_W+1:0] DEPTH_C = (PTR_W + 2)'(DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [DATA_SIZE-1:0] inst;
    } entry_t;

    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] tag_pc;
    logic [PC_W-1:0] last_pc;
    logic            inflight;

    logic            push;
    logic            pop;
    logic            full;
    logic            empty;
    logic [PTR_W:0]  count;
    logic [PTR_W+1:0] credit_used;
    entry_t          push_entry;
    entry_t          head_entry;

    // A pop in the same cycle is deliberately not credited back.
    assign credit_used = (PTR_W + 2)'(count) + (PTR_W + 2)'(inflight);
    assign ireq        = !RESET && !redirect && (credit_used < DEPTH_C);
    assign iaddr       = fetch_pc[PC_W-1:2];

    assign push       = inflight && !redirect && !RESET && !full;
    assign pop        = inst_valid && id_ready;
    assign push_entry = '{pc: tag_pc, inst: idata};

    assign inst_valid = !empty;
    assign inst_if    = inst_valid ? head_entry.inst : DATA_SIZE'(NOP_INST);
    assign pc_if      = inst_valid ? head_entry.pc : last_pc;

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RESET),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (push_entry),
        .full  (full),
        .empty (empty),
        .count (count),
        .head  (head_entry)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_pc <= '0;
            tag_pc   <= '0;
            last_pc  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= ireq;
            if (inst_valid) last_pc <= head_entry.pc;
            if (redirect) begin
                fetch_pc <= redirect_pc & ~PC_W'(3);
            end else if (ireq) begin
                tag_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + PC_W'(4);
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push)     fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign fetch_count = fetch_cnt;
    assign flush_count = flush_cnt;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-based reference model plus directed
// and randomized stimulus. Stats expectations follow FETCH_STATS_EN.
module tb_fetch_unit;

    localparam int DATA_SIZE = 32;
    localparam int ADDR_SIZE = 10;
    localparam int DEPTH     = 4;
`ifdef FETCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        redirect = 1'b0;
    logic [11:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic [31:0] idata = '0;
    logic [9:0]  iaddr;
    logic        ireq;
    logic        inst_valid;
    logic [31:0] inst_if;
    logic [11:0] pc_if;
    logic [31:0] fetch_count;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;

    fetch_unit #(
        .DATA_SIZE (DATA_SIZE),
        .ADDR_SIZE (ADDR_SIZE),
        .DEPTH     (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .iaddr       (iaddr),
        .ireq        (ireq),
        .idata       (idata),
        .id_ready    (id_ready),
        .inst_valid  (inst_valid),
        .inst_if     (inst_if),
        .pc_if       (pc_if),
        .fetch_count (fetch_count),
        .flush_count (flush_count)
    );

    always #5 CLK = ~CLK;

    logic [31:0] rom [0:1023];
    initial for (int i = 0; i < 1024; i++) rom[i] = 32'h1000_0000 + i;

    // Registered ROM: data for the address issued last cycle.
    always @(posedge CLK) if (ireq) idata <= rom[iaddr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of {pc, inst}, fetch pc, one in-flight slot.
    typedef struct {
        logic [11:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [11:0] m_pc = '0;
    logic [11:0] m_ipc = '0;
    bit          m_inflight = 0;
    logic [11:0] m_last = '0;
    int          m_fetches = 0;
    int          m_flushes = 0;
    bit          armed = 0;

    always @(negedge CLK) begin
        bit          e_ireq;
        bit          e_valid;
        logic [31:0] e_inst;
        logic [11:0] e_pc;
        ent_t        ne;
        #1;
        e_ireq  = !RESET && !redirect && ((q.size() + int'(m_inflight)) < DEPTH);
        e_valid = (q.size() != 0);
        e_inst  = e_valid ? q[0].inst : 32'h0000_0013;
        e_pc    = e_valid ? q[0].pc : m_last;
        if (armed) begin
            chk("ireq", 64'(ireq), 64'(e_ireq));
            chk("iaddr", 64'(iaddr), 64'(m_pc >> 2));
            chk("inst_valid", 64'(inst_valid), 64'(e_valid));
            chk("inst_if", 64'(inst_if), 64'(e_inst));
            chk("pc_if", 64'(pc_if), 64'(e_pc));
            chk("fetch_count", 64'(fetch_count), STATS ? 64'(m_fetches) : 64'd0);
            chk("flush_count", 64'(flush_count), STATS ? 64'(m_flushes) : 64'd0);
        end
        if (RESET) begin
            q.delete();
            m_pc = '0;
            m_inflight = 0;
            m_last = '0;
            m_fetches = 0;
            m_flushes = 0;
            armed = 1;
        end else begin
            if (e_valid) m_last = q[0].pc;
            if (redirect) begin
                q.delete();
                m_pc = redirect_pc & 12'hFFC;
                m_inflight = 0;
                m_flushes++;
            end else begin
                if (e_valid && id_ready) void'(q.pop_front());
                if (m_inflight) begin
                    ne.pc = m_ipc;
                    ne.inst = rom[m_ipc[11:2]];
                    q.push_back(ne);
                    m_fetches++;
                end
                if (e_ireq) begin
                    m_ipc = m_pc;
                    m_pc = m_pc + 12'd4;
                end
                m_inflight = e_ireq;
            end
        end
    end

    task automatic step(input logic r, input logic d, input logic [11:0] p, input logic rdy);
        @(negedge CLK);
        RESET = r;
        redirect = d;
        redirect_pc = p;
        id_ready = rdy;
        #2;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    initial begin
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Streaming with id_ready high.
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 0, 1);
            if (k == 0) begin
                chk("t1_ireq0", 64'(ireq), 64'd1);
                chk("t1_iaddr0", 64'(iaddr), 64'd0);
            end
            if (k < 2) chk("t1_empty", 64'(inst_valid), 64'd0);
            else begin
                chk("t1_valid", 64'(inst_valid), 64'd1);
                chk("t1_pc", 64'(pc_if), 64'(4 * (k - 2)));
                chk("t1_inst", 64'(inst_if), 64'(32'h1000_0000 + k - 2));
            end
        end

        // Stall for 10 cycles, then release.
        step(1, 0, 0, 0);
        for (int k = 0; k < 17; k++) begin
            step(0, 0, 0, (k < 2 || k >= 12));
            if (k == 5) begin
                chk("t2_full_ireq", 64'(ireq), 64'd0);
                chk("t2_head", 64'(pc_if), 64'd0);
            end
            if (k == 12) chk("t2_nocredit", 64'(ireq), 64'd0);
            if (k >= 12) begin
                chk("t2_valid", 64'(inst_valid), 64'd1);
                chk("t2_pc", 64'(pc_if), 64'(4 * (k - 12)));
            end
        end

        // Redirect with three queued and one in flight.
        step(1, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            step(0, (k == 4), 12'h103, (k > 4));
            if (k == 4) begin
                chk("t3_ireq_redir", 64'(ireq), 64'd0);
                chk("t3_q_before", 64'(inst_valid), 64'd1);
            end
            if (k == 5) begin
                chk("t3_flushed", 64'(inst_valid), 64'd0);
                chk("t3_iaddr", 64'(iaddr), 64'h40);
            end
            if (k == 6) chk("t3_still_empty", 64'(inst_valid), 64'd0);
            if (k == 7) begin
                chk("t3_target_pc", 64'(pc_if), 64'h100);
                chk("t3_target_inst", 64'(inst_if), 64'h1000_0040);
            end
            if (k == 8) chk("t3_next_pc", 64'(pc_if), 64'h104);
        end

        // PC wrap at the top of the ROM.
        for (int k = 0; k < 6; k++) begin
            step(0, (k == 0), 12'hFFC, 1);
            if (k == 1) chk("t4_iaddr_top", 64'(iaddr), 64'd1023);
            if (k == 2) chk("t4_iaddr_wrap", 64'(iaddr), 64'd0);
            if (k == 3) chk("t4_pc_top", 64'(pc_if), 64'hFFC);
            if (k == 4) chk("t4_pc_wrap", 64'(pc_if), 64'h000);
        end

        // Reset mid-stream with redirect also high.
        for (int k = 0; k < 6; k++) begin
            step((k == 2), (k == 2), 12'h200, 1);
            if (k == 3) begin
                chk("t5_valid", 64'(inst_valid), 64'd0);
                chk("t5_iaddr", 64'(iaddr), 64'd0);
            end
            if (k == 5) chk("t5_restart_pc", 64'(pc_if), 64'd0);
        end

        // Statistics: two redirects in a short run.
        step(1, 0, 0, 0);
        for (int k = 0; k < 22; k++) begin
            step(0, (k == 8 || k == 15), (k == 8) ? 12'h300 : 12'h7F0, 1);
        end
        chk("t6_flush_count", 64'(flush_count), STATS ? 64'd2 : 64'd0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(199) == 0), ($urandom_range(19) == 0),
                 12'($urandom), ($urandom_range(9) < 7));
        end

        step(0, 0, 0, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
